pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Pipeline sequencer around the ID-stage branch resolver (control_hazard). Detects load-use and
//   branch-operand RAW hazards, holds PC and IF/ID for a counted number of cycles while bubbling
//   ID/EX, then lets control_hazard resolve. Selects the branch target and flushes IF/ID on a taken
//   branch, and keeps saturating stall/flush performance counters.
// PARAMETERS
//   AWIDTH      5   register-address width (rs/rt/rd)
//   CNT_WIDTH   16  width of each performance counter
// PORTS
//   i_clk          in   1          clock, rising edge
//   i_rst          in   1          asynchronous, active-low reset
//   i_hold         in   1          external freeze (memory wait); overrides everything
//   i_id_valid     in   1          ID stage holds a real instruction
//   i_id_branch    in   1          ID instruction is BEQ/BNE (same as control_hazard i_branch)
//   i_id_uses_rt   in   1          ID instruction reads rt
//   i_id_rs        in   AWIDTH     ID source register rs
//   i_id_rt        in   AWIDTH     ID source register rt
//   i_compare      in   1          control_hazard o_compare (branch condition true)
//   i_ex_regwrite  in   1          EX instruction writes a register
//   i_ex_memread   in   1          EX instruction is a load
//   i_ex_rd        in   AWIDTH     EX destination register
//   i_mem_memread  in   1          MEM instruction is a load
//   i_mem_rd       in   AWIDTH     MEM destination register
//   o_pc_write     out  1          PC register enable
//   o_if_id_write  out  1          IF/ID register enable
//   o_id_ex_bubble out  1          insert NOP into ID/EX
//   o_if_id_flush  out  1          clear IF/ID (taken branch)
//   o_pc_sel       out  1          1 = PC takes control_hazard o_pc
//   o_stall_cnt    out  CNT_WIDTH  stall cycles, saturating
//   o_flush_cnt    out  CNT_WIDTH  taken-branch flushes, saturating
// BEHAVIOUR
//   Reset (i_rst=0, async): state=RUN, remaining=0, counters=0. Outputs during reset:
//     o_pc_write=1, o_if_id_write=1, all others 0.
//   Match(x,rd) = (rd != 0) && (rd == rs || (i_id_uses_rt && rd == rt)); only evaluated when i_id_valid.
//   need (combinational, first true wins):
//     branch & i_ex_memread & Match(ex_rd)    -> 2
//     branch & i_ex_regwrite & Match(ex_rd)   -> 1
//     branch & i_mem_memread & Match(mem_rd)  -> 1
//     !branch & i_ex_memread & Match(ex_rd)   -> 1
//     otherwise                               -> 0
//   States: RUN, STALL. remaining is a 2-bit down-counter.
//   RUN, need>0: stall cycle (pc_write=0, if_id_write=0, bubble=1, pc_sel=0, flush=0);
//     if need==2 -> STALL, remaining=1; if need==1 -> stay RUN (re-evaluate next cycle).
//   STALL: stall cycle; need is NOT re-evaluated; remaining-1; at remaining==1 -> RUN next cycle.
//   RUN, need==0: pc_write=1, if_id_write=1, bubble=0. If i_id_valid & i_id_branch & i_compare:
//     pc_sel=1 and if_id_flush=1 in the same cycle (combinational, zero latency).
//   A branch is never resolved in a stall cycle (pc_sel=0, flush=0 whenever bubble=1).
//   i_hold=1: pc_write=0, if_id_write=0, bubble=0, flush=0, pc_sel=0; state, remaining and counters
//     frozen. Hold has priority over stall and branch.
//   Counters: o_stall_cnt +1 on each cycle with bubble=1; o_flush_cnt +1 on each cycle with
//     if_id_flush=1; both saturate at all-ones, registered (visible the cycle after the event).
//   Reset asserted mid-STALL: immediate return to RUN and reset outputs; no residual stall.
// STRUCTURE
//   Shared definitions header: state encodings (RUN/STALL), `AWIDTH, and BEQ/BNE opcodes, alongside the
//   existing PC_WIDTH/DWIDTH/OPCODE_WIDTH defines.
//   Sub-module hazard_detect: combinational, computes need[1:0] from ID/EX/MEM fields.
//   Top holds FSM, remaining counter, output decode and the two saturating counters.
// TESTING
//   1 ID add rs=3, EX lw rd=3 -> one cycle pc_write=0,bubble=1; next cycle pc_write=1; stall_cnt=1.
//   2 ID beq rs=4,rt=5, EX lw rd=5 -> exactly 2 stall cycles (state STALL on 2nd), pc_sel=0 both;
//     then with i_compare=1 -> pc_sel=1, if_id_flush=1 one cycle; flush_cnt=1, stall_cnt=2.
//   3 ID bne rs=7, EX add rd=7 -> 1 stall; EX rd=0 with rs=0 -> no stall (r0 exempt).
//   4 ID beq, no hazard, i_compare=0 -> pc_sel=0, flush=0, pc_write=1; i_compare=1 -> pc_sel=1.
//   5 i_hold=1 during STALL with remaining=1 -> all enables 0, state frozen; release -> one
//     more stall cycle, then RUN; stall_cnt counts only bubble cycles.
//   6 Assert i_rst=0 mid-STALL -> RUN, pc_write=1, counters 0 asynchronously; 70000 back-to-back
//     load-use stalls -> o_stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard sequencer: FSM states, widths and branch opcodes.
package pipeline_hazard_ctrl_pkg;

  localparam int PC_WIDTH     = 32;
  localparam int DWIDTH       = 32;
  localparam int OPCODE_WIDTH = 6;
  localparam int DEF_AWIDTH   = 5;

  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE = 6'h05;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  // Number of stall cycles an ID instruction must wait before it may proceed.
  typedef logic [1:0] need_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard detector: how many stall cycles the ID instruction needs.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              i_id_valid,
  input  logic              i_id_branch,
  input  logic              i_id_uses_rt,
  input  logic [AWIDTH-1:0] i_id_rs,
  input  logic [AWIDTH-1:0] i_id_rt,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_memread,
  input  logic [AWIDTH-1:0] i_ex_rd,
  input  logic              i_mem_memread,
  input  logic [AWIDTH-1:0] i_mem_rd,
  output need_t             o_need
);

  logic w_ex_match;
  logic w_mem_match;

  always_comb begin
    w_ex_match  = i_id_valid && (i_ex_rd != '0) &&
                  ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
    w_mem_match = i_id_valid && (i_mem_rd != '0) &&
                  ((i_mem_rd == i_id_rs) || (i_id_uses_rt && (i_mem_rd == i_id_rt)));
  end

  // Branches compare in ID, so they also wait on ALU results and loads still in MEM.
  always_comb begin
    o_need = 2'd0;
    if (i_id_branch && i_ex_memread && w_ex_match)
      o_need = 2'd2;
    else if (i_id_branch && i_ex_regwrite && w_ex_match)
      o_need = 2'd1;
    else if (i_id_branch && i_mem_memread && w_mem_match)
      o_need = 2'd1;
    else if (!i_id_branch && i_ex_memread && w_ex_match)
      o_need = 2'd1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: stalls PC/IF-ID on RAW hazards, steers taken branches, counts events.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_hold,
  input  logic                 i_id_valid,
  input  logic                 i_id_branch,
  input  logic                 i_id_uses_rt,
  input  logic [AWIDTH-1:0]    i_id_rs,
  input  logic [AWIDTH-1:0]    i_id_rt,
  input  logic                 i_compare,
  input  logic                 i_ex_regwrite,
  input  logic                 i_ex_memread,
  input  logic [AWIDTH-1:0]    i_ex_rd,
  input  logic                 i_mem_memread,
  input  logic [AWIDTH-1:0]    i_mem_rd,
  output logic                 o_pc_write,
  output logic                 o_if_id_write,
  output logic                 o_id_ex_bubble,
  output logic                 o_if_id_flush,
  output logic                 o_pc_sel,
  output logic [CNT_WIDTH-1:0] o_stall_cnt,
  output logic [CNT_WIDTH-1:0] o_flush_cnt
);

  hz_state_e            r_state;
  logic [1:0]           r_remaining;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  need_t                w_need;

  hazard_detect #(.AWIDTH(AWIDTH)) u_hazard_detect (
    .i_id_valid    (i_id_valid),
    .i_id_branch   (i_id_branch),
    .i_id_uses_rt  (i_id_uses_rt),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_ex_regwrite (i_ex_regwrite),
    .i_ex_memread  (i_ex_memread),
    .i_ex_rd       (i_ex_rd),
    .i_mem_memread (i_mem_memread),
    .i_mem_rd      (i_mem_rd),
    .o_need        (w_need)
  );

  // Decode is combinational so stalls and branch redirects take effect in the same cycle;
  // reset is folded in so the async reset values appear immediately.
  always_comb begin
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_id_ex_bubble = 1'b0;
    o_if_id_flush  = 1'b0;
    o_pc_sel       = 1'b0;
    if (!i_rst) begin
      o_pc_write    = 1'b1;
    end else if (i_hold) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
    end else if ((r_state == ST_STALL) || (w_need != 2'd0)) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b1;
    end else if (i_id_valid && i_id_branch && i_compare) begin
      o_pc_sel      = 1'b1;
      o_if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_RUN;
      r_remaining <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!i_hold) begin
      case (r_state)
        ST_RUN: begin
          if (w_need == 2'd2) begin
            r_state     <= ST_STALL;
            r_remaining <= 2'd1;
          end
        end
        ST_STALL: begin
          r_remaining <= r_remaining - 2'd1;
          if (r_remaining <= 2'd1)
            r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
      if (o_id_ex_bubble && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (o_if_id_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized model comparison.
module tb_pipeline_hazard_ctrl;

  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, id_valid, id_branch, id_uses_rt, compare;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        ex_regwrite, ex_memread, mem_memread;
  logic        pc_write, if_id_write, bubble, flush, pc_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: number of stall cycles still owed plus event counters.
  int m_pending, m_stall, m_flush, e_need;
  bit e_pc_write, e_if_id_write, e_bubble, e_flush, e_pc_sel;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.AWIDTH(5), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_hold(hold),
    .i_id_valid(id_valid), .i_id_branch(id_branch), .i_id_uses_rt(id_uses_rt),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_compare(compare),
    .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread), .i_ex_rd(ex_rd),
    .i_mem_memread(mem_memread), .i_mem_rd(mem_rd),
    .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_id_ex_bubble(bubble),
    .o_if_id_flush(flush), .o_pc_sel(pc_sel),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  function automatic bit reads(input logic [4:0] rd);
    return id_valid && (rd != 0) && (rd == id_rs || (id_uses_rt && rd == id_rt));
  endfunction

  function automatic int model_need();
    if (id_branch && ex_memread && reads(ex_rd)) return 2;
    if (id_branch && ex_regwrite && reads(ex_rd)) return 1;
    if (id_branch && mem_memread && reads(mem_rd)) return 1;
    if (!id_branch && ex_memread && reads(ex_rd)) return 1;
    return 0;
  endfunction

  task automatic model_outputs();
    bit stalled;
    e_need = model_need();
    stalled = (m_pending > 0) || (e_need > 0);
    e_pc_write    = !rst_n || (!hold && !stalled);
    e_if_id_write = e_pc_write;
    e_bubble      = rst_n && !hold && stalled;
    e_pc_sel      = rst_n && !hold && !stalled && id_valid && id_branch && compare;
    e_flush       = e_pc_sel;
  endtask

  task automatic step();
    model_outputs();
    @(posedge clk);
    if (rst_n && !hold) begin
      if (e_bubble && m_stall < CMAX) m_stall++;
      if (e_flush && m_flush < CMAX) m_flush++;
      if (m_pending > 0) m_pending--;
      else if (e_need > 0) m_pending = e_need - 1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hold = 0; id_valid = 0; id_branch = 0; id_uses_rt = 0; compare = 0;
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    ex_regwrite = 0; ex_memread = 0; mem_memread = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    m_pending = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    m_pending = 0; m_stall = 0; m_flush = 0;
    id_valid = 1; id_rs = 3; ex_memread = 1; ex_regwrite = 1; ex_rd = 3;
    @(negedge clk); #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_bad++; $display("FAIL reset_pc_write: got %b want 1", pc_write); end
    n_cmp++; if (if_id_write !== 1'b1) begin n_bad++; $display("FAIL reset_if_id_write: got %b want 1", if_id_write); end
    n_cmp++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL reset_bubble: got %b want 0", bubble); end
    n_cmp++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1; id_rs = 3; ex_memread = 1; ex_regwrite = 1; ex_rd = 3;
    #1;
    n_cmp++; if (pc_write !== 1'b0 || bubble !== 1'b1) begin n_bad++; $display("FAIL load_use_stall: got pc_write=%b bubble=%b want 0/1", pc_write, bubble); end
    step();
    ex_memread = 0; ex_regwrite = 0;
    #1;
    n_cmp++; if (pc_write !== 1'b1 || bubble !== 1'b0) begin n_bad++; $display("FAIL load_use_release: got pc_write=%b bubble=%b want 1/0", pc_write, bubble); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt); end
    step();
  endtask

  task automatic test_branch_load();
    do_reset();
    id_valid = 1; id_branch = 1; id_uses_rt = 1; id_rs = 4; id_rt = 5;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5;
    #1;
    n_cmp++; if (bubble !== 1'b1 || pc_sel !== 1'b0) begin n_bad++; $display("FAIL br_load_stall1: got bubble=%b pc_sel=%b want 1/0", bubble, pc_sel); end
    step();
    // Hazard gone and condition true, but the second stall is owed regardless.
    ex_memread = 0; ex_regwrite = 0; compare = 1;
    #1;
    n_cmp++; if (bubble !== 1'b1 || pc_sel !== 1'b0 || flush !== 1'b0) begin n_bad++; $display("FAIL br_load_stall2: got bubble=%b pc_sel=%b flush=%b want 1/0/0", bubble, pc_sel, flush); end
    step();
    #1;
    n_cmp++; if (pc_sel !== 1'b1 || flush !== 1'b1 || pc_write !== 1'b1) begin n_bad++; $display("FAIL br_load_resolve: got pc_sel=%b flush=%b pc_write=%b want 1/1/1", pc_sel, flush, pc_write); end
    n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL br_load_stall_cnt: got %0d want 2", stall_cnt); end
    step();
    id_valid = 0; compare = 0;
    #1;
    n_cmp++; if (flush_cnt !== 16'd1 || flush !== 1'b0) begin n_bad++; $display("FAIL br_load_flush_cnt: got cnt=%0d flush=%b want 1/0", flush_cnt, flush); end
    step();
  endtask

  task automatic test_branch_alu();
    do_reset();
    id_valid = 1; id_branch = 1; id_uses_rt = 1; id_rs = 7; id_rt = 1;
    ex_regwrite = 1; ex_rd = 7;
    #1;
    n_cmp++; if (bubble !== 1'b1) begin n_bad++; $display("FAIL bne_alu_stall: got bubble=%b want 1", bubble); end
    step();
    ex_regwrite = 0;
    #1;
    n_cmp++; if (bubble !== 1'b0 || stall_cnt !== 16'd1) begin n_bad++; $display("FAIL bne_alu_release: got bubble=%b cnt=%0d want 0/1", bubble, stall_cnt); end
    step();
    id_rs = 0; id_rt = 0; ex_rd = 0; ex_regwrite = 1; ex_memread = 1; mem_memread = 1; mem_rd = 0;
    #1;
    n_cmp++; if (bubble !== 1'b0 || pc_write !== 1'b1) begin n_bad++; $display("FAIL r0_exempt: got bubble=%b pc_write=%b want 0/1", bubble, pc_write); end
    step();
  endtask

  task automatic test_branch_nohazard();
    do_reset();
    id_valid = 1; id_branch = 1; id_uses_rt = 1; id_rs = 2; id_rt = 6; ex_rd = 9; ex_regwrite = 1;
    #1;
    n_cmp++; if (pc_sel !== 1'b0 || flush !== 1'b0 || pc_write !== 1'b1) begin n_bad++; $display("FAIL br_not_taken: got pc_sel=%b flush=%b pc_write=%b want 0/0/1", pc_sel, flush, pc_write); end
    step();
    compare = 1;
    #1;
    n_cmp++; if (pc_sel !== 1'b1 || flush !== 1'b1) begin n_bad++; $display("FAIL br_taken: got pc_sel=%b flush=%b want 1/1", pc_sel, flush); end
    step();
  endtask

  task automatic test_hold_stall();
    do_reset();
    id_valid = 1; id_branch = 1; id_uses_rt = 1; id_rs = 4; id_rt = 5; ex_memread = 1; ex_rd = 5;
    step();
    ex_memread = 0; hold = 1;
    for (int unsigned k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || bubble !== 1'b0 || pc_sel !== 1'b0) begin n_bad++; $display("FAIL hold_freeze: got pc_write=%b if_id_write=%b bubble=%b pc_sel=%b want 0/0/0/0", pc_write, if_id_write, bubble, pc_sel); end
      step();
    end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL hold_stall_cnt: got %0d want 1", stall_cnt); end
    hold = 0;
    #1;
    n_cmp++; if (bubble !== 1'b1) begin n_bad++; $display("FAIL hold_resume_stall: got bubble=%b want 1", bubble); end
    step();
    #1;
    n_cmp++; if (bubble !== 1'b0 || stall_cnt !== 16'd2) begin n_bad++; $display("FAIL hold_back_to_run: got bubble=%b cnt=%0d want 0/2", bubble, stall_cnt); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    id_valid = 1; id_branch = 1; id_rs = 4; ex_memread = 1; ex_rd = 4;
    step();
    ex_memread = 0;
    #2;
    rst_n = 0;
    m_pending = 0; m_stall = 0; m_flush = 0;
    #1;
    n_cmp++; if (pc_write !== 1'b1 || bubble !== 1'b0 || stall_cnt !== 16'd0) begin n_bad++; $display("FAIL async_reset: got pc_write=%b bubble=%b cnt=%0d want 1/0/0", pc_write, bubble, stall_cnt); end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++; if (bubble !== 1'b0 || pc_write !== 1'b1) begin n_bad++; $display("FAIL no_residual_stall: got bubble=%b pc_write=%b want 0/1", bubble, pc_write); end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    id_valid = 1; id_rs = 3; ex_memread = 1; ex_rd = 3;
    for (int unsigned k = 0; k < 70000; k++) step();
    #1;
    n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL stall_saturate: got %0h want ffff", stall_cnt); end
    n_cmp++; if (int'(stall_cnt) != m_stall) begin n_bad++; $display("FAIL stall_saturate_model: got %0d want %0d", stall_cnt, m_stall); end
  endtask

  task automatic test_random();
    do_reset();
    for (int unsigned k = 0; k < 1500; k++) begin
      hold        = ($urandom_range(0, 9) == 0);
      id_valid    = ($urandom_range(0, 7) != 0);
      id_branch   = $urandom_range(0, 1) == 1;
      id_uses_rt  = $urandom_range(0, 1) == 1;
      compare     = $urandom_range(0, 1) == 1;
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      mem_rd      = 5'($urandom_range(0, 3));
      ex_regwrite = $urandom_range(0, 1) == 1;
      ex_memread  = ($urandom_range(0, 3) == 0);
      mem_memread = ($urandom_range(0, 3) == 0);
      #1;
      model_outputs();
      n_cmp++; if (pc_write !== e_pc_write || if_id_write !== e_if_id_write) begin n_bad++; $display("FAIL rnd_enables[%0d]: got %b%b want %b%b", k, pc_write, if_id_write, e_pc_write, e_if_id_write); end
      n_cmp++; if (bubble !== e_bubble) begin n_bad++; $display("FAIL rnd_bubble[%0d]: got %b want %b", k, bubble, e_bubble); end
      n_cmp++; if (pc_sel !== e_pc_sel || flush !== e_flush) begin n_bad++; $display("FAIL rnd_branch[%0d]: got %b%b want %b%b", k, pc_sel, flush, e_pc_sel, e_flush); end
      n_cmp++; if (int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush) begin n_bad++; $display("FAIL rnd_counters[%0d]: got %0d/%0d want %0d/%0d", k, stall_cnt, flush_cnt, m_stall, m_flush); end
      step();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_branch_nohazard();
    test_hold_stall();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
